// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment hex encoding table and segment bit indices
package seg7_pkg;
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
endpackage

// File: rtl/seg7_scan_capture_if.sv
// seg7_scan_capture_if: scanned display bus in, captured digits out
interface seg7_scan_capture_if #(parameter int NUM_DIGITS = 4);
  logic [NUM_DIGITS-1:0] an;
  logic [6:0] seg;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0] digit_err;
  logic frame_valid;
  modport master (output an, seg, input digits, digit_err, frame_valid);
  modport slave (input an, seg, output digits, digit_err, frame_valid);
endinterface

// File: rtl/seg7_pattern_to_hex.sv
// seg7_pattern_to_hex: reverse lookup of an active-high segment pattern to its hex nibble
module seg7_pattern_to_hex
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic       hit,
  output logic [3:0] nibble
);
  always_comb begin
    hit = 1'b0;
    nibble = 4'h0;
    for (int k = 0; k < 16; k++) begin
      if (seg != SEG_BLANK && seg == HEX_SEG[k]) begin
        hit = 1'b1;
        nibble = 4'(k);
      end
    end
  end
endmodule

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: rebuilds per-digit hex nibbles from a multiplexed 7-segment bus
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int SETTLE_CYCLES  = 4,
  parameter bit AN_ACTIVE_LOW  = 1,
  parameter bit SEG_ACTIVE_LOW = 0
) (
  input logic clk,
  input logic rst,
  seg7_scan_capture_if.slave bus
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] AN_INV = AN_ACTIVE_LOW ? '1 : '0;
  localparam logic [6:0] SEG_INV = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  logic [NUM_DIGITS-1:0] an_q, an_d, prev_an_q, seen_q, seen_d, seen_n, err_q, err_d;
  logic [6:0] seg_q, seg_d, prev_seg_q;
  logic [7:0] cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic done_q, done_d, frame_q, frame_d, valid, same, cap, hit;
  logic [IW-1:0] idx;
  logic [3:0] nibble;
  seg7_pattern_to_hex u_lookup (.seg(seg_q), .hit(hit), .nibble(nibble));
  always_comb begin
    an_d = bus.an ^ AN_INV;
    seg_d = bus.seg ^ SEG_INV;
    valid = $onehot(an_q);
    idx = '0;
    for (int k = 0; k < NUM_DIGITS; k++) idx = an_q[k] ? IW'(k) : idx;
    same = an_q == prev_an_q && seg_q == prev_seg_q;
    cnt_d = !valid ? 8'd0 : !same ? 8'd1 : cnt_q == 8'hFF ? cnt_q : cnt_q + 8'd1;
    cap = valid && !done_q && cnt_d == 8'(SETTLE_CYCLES);
    done_d = valid && (cap || (same && done_q));
    digits_d = digits_q;
    err_d = err_q;
    seen_n = seen_q;
    if (cap) begin
      if (hit) digits_d[4*idx +: 4] = nibble;
      err_d[idx] = !hit;
      seen_n[idx] = 1'b1;
    end
    frame_d = &seen_n;
    seen_d = frame_d ? '0 : seen_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q <= '0;
      seg_q <= '0;
      prev_an_q <= '0;
      prev_seg_q <= '0;
      cnt_q <= '0;
      done_q <= 1'b0;
      digits_q <= '0;
      err_q <= '0;
      seen_q <= '0;
      frame_q <= 1'b0;
    end else begin
      an_q <= an_d;
      seg_q <= seg_d;
      prev_an_q <= an_q;
      prev_seg_q <= seg_q;
      cnt_q <= cnt_d;
      done_q <= done_d;
      digits_q <= digits_d;
      err_q <= err_d;
      seen_q <= seen_d;
      frame_q <= frame_d;
    end
  end
  assign bus.digits = digits_q;
  assign bus.digit_err = err_q;
  assign bus.frame_valid = frame_q;
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: directed scans checked against a dwell-history model of the display reader
module tb_seg7_scan_capture;
  localparam int N = 4;
  localparam int S = 4;
  localparam logic [6:0] HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  logic clk = 1'b0;
  logic rst = 1'b1;
  int pass_cnt = 0;
  int total_cnt = 0;
  int frames = 0;
  seg7_scan_capture_if #(.NUM_DIGITS(N)) bus ();
  seg7_scan_capture #(
    .NUM_DIGITS(N), .SETTLE_CYCLES(S), .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b0)
  ) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  logic [10:0] hist [$];
  logic [3:0] m_dig [N];
  logic [N-1:0] m_err = '0;
  logic [N-1:0] m_seen = '0;
  logic m_frame = 1'b0;
  always @(posedge clk) begin : model
    logic [10:0] cur, last;
    int run, pos, nib;
    cur = {~bus.an, bus.seg};
    m_frame = 1'b0;
    if (rst) begin
      hist = {};
      for (int k = 0; k < N; k++) m_dig[k] = 4'h0;
      m_err = '0;
      m_seen = '0;
      hist.push_back(11'd0);
    end else begin
      run = 0;
      if (hist.size() > 0) begin
        last = hist[hist.size()-1];
        if ($countones(last[10:7]) == 1)
          while (run < hist.size() && hist[hist.size()-1-run] == last) run++;
        if (run == S) begin
          pos = 0;
          for (int k = 0; k < N; k++) if (last[7+k]) pos = k;
          nib = -1;
          for (int v = 0; v < 16; v++) if (HEX[v] == last[6:0]) nib = v;
          if (nib >= 0) begin
            m_dig[pos] = 4'(nib);
            m_err[pos] = 1'b0;
          end else m_err[pos] = 1'b1;
          m_seen[pos] = 1'b1;
          if (&m_seen) begin
            m_frame = 1'b1;
            m_seen = '0;
          end
        end
      end
      hist.push_back(cur);
      if (hist.size() > S + 1) void'(hist.pop_front());
    end
  end
  always @(negedge clk) begin : compare
    logic [4*N-1:0] ed;
    for (int k = 0; k < N; k++) ed[4*k +: 4] = m_dig[k];
    total_cnt++;
    if (bus.digits === ed && bus.digit_err === m_err && bus.frame_valid === m_frame) pass_cnt++;
    else $display("FAIL cycle_model t=%0t digits=%h want %h err=%b want %b frame=%b want %b",
                  $time, bus.digits, ed, bus.digit_err, m_err, bus.frame_valid, m_frame);
    if (bus.frame_valid === 1'b1) frames++;
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic step(input logic [3:0] a, input logic [6:0] s, input int n);
    bus.an = a;
    bus.seg = s;
    repeat (n) @(negedge clk);
    #1;
  endtask
  initial begin
    int f0;
    logic [3:0] a;
    bus.an = 4'hF;
    bus.seg = 7'h00;
    repeat (3) @(negedge clk);
    #1;
    rst = 1'b0;
    chk("reset_digits", 32'(bus.digits), 0);
    chk("reset_err", 32'(bus.digit_err), 0);
    chk("reset_frame", 32'(bus.frame_valid), 0);
    step(4'b1110, HEX[8], 4);
    chk("latency_before", 32'(bus.digits[3:0]), 0);
    step(4'b1110, HEX[8], 1);
    chk("latency_at", 32'(bus.digits[3:0]), 8);
    step(4'b1110, HEX[8], 35);
    chk("long_dwell_err", 32'(bus.digit_err), 0);
    chk("long_dwell_no_frame", frames, 0);
    f0 = frames;
    for (int i = 0; i < N; i++) begin
      a = 4'b0001 << i;
      step(~a, HEX[i+1], 8);
    end
    chk("loopback_digits", 32'(bus.digits), 32'h4321);
    chk("loopback_err", 32'(bus.digit_err), 0);
    chk("loopback_frames", frames - f0, 1);
    step(4'b1011, 7'h00, 8);
    chk("blank_err", 32'(bus.digit_err[2]), 1);
    chk("blank_keep", 32'(bus.digits[11:8]), 3);
    step(4'b1011, 7'h49, 8);
    chk("illegal_err", 32'(bus.digit_err[2]), 1);
    chk("illegal_keep", 32'(bus.digits[11:8]), 3);
    step(4'b1011, 7'h5E, 8);
    chk("legal_clears_err", 32'(bus.digit_err[2]), 0);
    chk("legal_d", 32'(bus.digits[11:8]), 32'hD);
    step(4'b1101, HEX[5], 3);
    step(4'b1101, HEX[6], 2);
    step(4'b1101, HEX[5], 4);
    chk("glitch_hold", 32'(bus.digits[7:4]), 2);
    step(4'b1101, HEX[5], 1);
    chk("post_glitch", 32'(bus.digits[7:4]), 5);
    f0 = frames;
    step(4'b1111, HEX[7], 6);
    step(4'b1100, HEX[7], 6);
    chk("idle_digits", 32'(bus.digits), 32'h4D51);
    chk("idle_no_frame", frames - f0, 0);
    step(4'b1110, HEX[9], 8);
    chk("three_seen_no_frame", frames - f0, 0);
    rst = 1'b1;
    step(4'b1110, HEX[9], 2);
    rst = 1'b0;
    chk("midrst_digits", 32'(bus.digits), 0);
    chk("midrst_err", 32'(bus.digit_err), 0);
    chk("midrst_frame", 32'(bus.frame_valid), 0);
    f0 = frames;
    step(4'b1110, HEX[7], 6);
    step(4'b1101, HEX[8], 6);
    step(4'b1011, HEX[9], 6);
    chk("rescan_partial", frames - f0, 0);
    step(4'b0111, HEX[10], 6);
    chk("rescan_frame", frames - f0, 1);
    chk("rescan_digits", 32'(bus.digits), 32'hA987);
    for (int n = 0; n < 16; n++) begin
      step(4'b1110, HEX[n], 6);
      chk("sweep", 32'(bus.digits[3:0]), n);
    end
    chk("sweep_err", 32'(bus.digit_err), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
